// File: rtl/beat_pkg.sv
// Shared types and constants for the beat sequencer.
package beat_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause
  } beat_state_e;

  localparam int unsigned STEPS_DEFAULT = 16;
  localparam int unsigned MIN_DIV       = 2;

endpackage

// File: rtl/tempo_tick.sv
// Down-counter with clear, reload and hold; done flags a zero count.
module tempo_tick #(
  parameter int unsigned WIDTH = 28
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             reload,
  input  logic             enable,
  input  logic [WIDTH-1:0] reload_val,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  assign count = count_q;
  assign done  = (count_q == '0);

  // Saturates at zero so an idle timer stays at terminal count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (reload) begin
      count_d = reload_val;
    end else if (enable && !done) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Start/stop/pause step sequencer with double-buffered pattern loading.
// Define GATE_LEN_EN to limit note_on to gate_len cycles per step.
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int unsigned STEPS = STEPS_DEFAULT,
  parameter int unsigned DIV_W = 28
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pause,
  input  logic                     load,
  input  logic [STEPS-1:0]         pattern_in,
  input  logic [DIV_W-1:0]         tempo_div,
  input  logic [DIV_W-1:0]         gate_len,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     step_tick,
  output logic                     note_on,
  output logic [STEPS-1:0]         step_led,
  output logic [STEPS-1:0]         pattern_q,
  output logic                     running
);

  localparam int unsigned StepW = $clog2(STEPS);
  localparam logic [DIV_W-1:0] MinDiv   = DIV_W'(MIN_DIV);
  localparam logic [StepW-1:0] LastStep = StepW'(STEPS - 1);

  beat_state_e      state_q, state_d;
  logic [STEPS-1:0] shadow_q, shadow_d, shadow_eff, pattern_d, step_led_d;
  logic             pending_q, pending_d, pend_eff, load_run;
  logic [StepW-1:0] step_d;
  logic [DIV_W-1:0] eff_div, step_cnt_unused;
  logic             step_done, counting, advance, begin_run, step_load;
  logic             act_pause, act_start, gate_on;

  assign eff_div   = (tempo_div < MinDiv) ? MinDiv : tempo_div;
  assign act_pause = !stop && pause && (state_q == StRun);
  assign act_start = !stop && !pause && start && (state_q != StRun);
  assign counting  = (state_q == StRun) && !stop && !pause;
  assign advance   = counting && step_done;
  assign begin_run = act_start && (state_q == StIdle);
  assign step_load = begin_run || advance;

  tempo_tick #(.WIDTH(DIV_W)) u_step_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (stop),
    .reload     (step_load),
    .enable     (counting),
    .reload_val (eff_div - DIV_W'(1)),
    .count      (step_cnt_unused),
    .done       (step_done)
  );

`ifdef GATE_LEN_EN
  logic [DIV_W-1:0] gate_val, gate_cnt;
  logic             gate_done;

  assign gate_val = (gate_len < eff_div) ? gate_len : eff_div;

  tempo_tick #(.WIDTH(DIV_W)) u_gate_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (stop),
    .reload     (step_load),
    .enable     (counting),
    .reload_val (gate_val),
    .count      (gate_cnt),
    .done       (gate_done)
  );

  // Gate state as it will be after this edge, so note_on stays registered.
  always_comb begin
    if (step_load) begin
      gate_on = (gate_val != '0);
    end else if (counting) begin
      gate_on = (gate_cnt > DIV_W'(1));
    end else begin
      gate_on = !gate_done;
    end
  end
`else
  logic unused_gate_len;
  assign unused_gate_len = ^gate_len;
  assign gate_on         = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = StIdle;
    end else if (act_pause) begin
      state_d = StPause;
    end else if (act_start) begin
      state_d = StRun;
    end
  end

  always_comb begin
    step_d = step;
    if (stop || begin_run) begin
      step_d = '0;
    end else if (advance) begin
      step_d = (step == LastStep) ? '0 : step + StepW'(1);
    end
  end

  // A load landing on a step boundary or a stop is applied on that same edge.
  assign load_run   = load && (state_q == StRun);
  assign pend_eff   = pending_q || load_run;
  assign shadow_eff = load_run ? pattern_in : shadow_q;

  always_comb begin
    pattern_d = pattern_q;
    shadow_d  = shadow_eff;
    pending_d = pend_eff;
    if (load && (state_q != StRun)) begin
      pattern_d = pattern_in;
      pending_d = 1'b0;
    end else if ((stop || advance) && pend_eff) begin
      pattern_d = shadow_eff;
      pending_d = 1'b0;
    end
  end

  assign step_led_d = (state_d == StIdle) ? '0 : (STEPS'(1) << step_d);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      step      <= '0;
      step_tick <= 1'b0;
      note_on   <= 1'b0;
      step_led  <= '0;
      pattern_q <= '0;
      running   <= 1'b0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step      <= step_d;
      step_tick <= step_load;
      note_on   <= (state_d == StRun) && pattern_d[step_d] && gate_on;
      step_led  <= step_led_d;
      pattern_q <= pattern_d;
      running   <= (state_d == StRun);
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed and random bench for beat_sequencer against a step-count reference model.
module tb_beat_sequencer;

  localparam int Steps  = 16;
  localparam int DivW   = 28;
  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MPause = 2;

  logic            clock      = 1'b0;
  logic            reset_n    = 1'b0;
  logic            start      = 1'b0;
  logic            stop       = 1'b0;
  logic            pause      = 1'b0;
  logic            load       = 1'b0;
  logic [15:0]     pattern_in = '0;
  logic [DivW-1:0] tempo_div  = 28'd4;
  logic [DivW-1:0] gate_len   = 28'd100;
  logic [3:0]      step;
  logic            step_tick, note_on, running;
  logic [15:0]     step_led, pattern_q;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: play mode, step, edges left until next step, gate cycles left.
  int          m_mode, m_step, m_rem, m_gate;
  bit          m_tick;
  logic [15:0] m_pat;
  logic [15:0] m_pend[$];

  beat_sequencer #(.STEPS(Steps), .DIV_W(DivW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .load       (load),
    .pattern_in (pattern_in),
    .tempo_div  (tempo_div),
    .gate_len   (gate_len),
    .step       (step),
    .step_tick  (step_tick),
    .note_on    (note_on),
    .step_led   (step_led),
    .pattern_q  (pattern_q),
    .running    (running)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MIdle; m_step = 0; m_rem = 0; m_gate = 0; m_tick = 0; m_pat = '0;
    m_pend.delete();
  endtask

  task automatic model_step();
    int eff, glen;
    eff  = (tempo_div < 2) ? 2 : int'(tempo_div);
    glen = (int'(gate_len) < eff) ? int'(gate_len) : eff;
    m_tick = 0;
    if (load && m_mode != MRun) begin
      m_pat = pattern_in;
      m_pend.delete();
    end else if (load) begin
      m_pend.delete();
      m_pend.push_back(pattern_in);
    end
    if (stop) begin
      if (m_pend.size() > 0) m_pat = m_pend.pop_front();
      m_mode = MIdle; m_step = 0; m_rem = 0; m_gate = 0;
    end else if (pause && m_mode == MRun) begin
      m_mode = MPause;
    end else if (start && !pause && m_mode != MRun) begin
      if (m_mode == MIdle) begin
        m_step = 0; m_rem = eff; m_gate = glen; m_tick = 1;
      end
      m_mode = MRun;
    end else if (m_mode == MRun) begin
      m_rem--;
      if (m_gate > 0) m_gate--;
      if (m_rem == 0) begin
        m_step = (m_step + 1) % Steps;
        m_rem  = eff; m_gate = glen; m_tick = 1;
        if (m_pend.size() > 0) m_pat = m_pend.pop_front();
      end
    end
  endtask

  task automatic check_all();
    bit exp_note;
`ifdef GATE_LEN_EN
    exp_note = (m_mode == MRun) && m_pat[m_step] && (m_gate > 0);
`else
    exp_note = (m_mode == MRun) && m_pat[m_step];
`endif
    check("running", running, m_mode == MRun);
    check("step", step, (m_mode == MIdle) ? 0 : m_step);
    check("step_tick", step_tick, m_tick);
    check("note_on", note_on, exp_note);
    check("step_led", step_led, (m_mode == MIdle) ? 0 : (32'd1 << m_step));
    check("pattern_q", pattern_q, m_pat);
  endtask

  task automatic tick_clk();
    @(posedge clock);
    model_step();
    #1;
    check_all();
    start = 0; stop = 0; pause = 0; load = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_running"}, running, 0);
    check({tag, "_step"}, step, 0);
    check({tag, "_tick"}, step_tick, 0);
    check({tag, "_note"}, note_on, 0);
    check({tag, "_led"}, step_led, 0);
  endtask

  initial begin
    int n_tick, n_note, gap;
    bit found;
    int gl_tab[3];
    int exp_tab[3];

    model_reset();
    #1;
    check_zero("reset");
    check("reset_pattern", pattern_q, 0);
    #12 reset_n = 1;
    @(negedge clock);

    // Basic run with two active steps.
    pattern_in = 16'h8001; load = 1;
    tick_clk();
    start = 1;
    n_tick = 0; n_note = 0;
    for (int i = 0; i < 64; i++) begin
      tick_clk();
      n_tick += int'(step_tick);
      n_note += int'(note_on);
    end
    check("ticks_in_64", n_tick, 16);
    check("notes_in_64", n_note, 8);
    tick_clk();
    check("wrap_step", step, 0);
    check("wrap_tick", step_tick, 1);

    // Load during RUN waits for the next step boundary.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_mode == MRun && m_step == 3 && m_rem == 2) found = 1;
      else tick_clk();
    end
    check("reach_step3", found, 1);
    pattern_in = 16'hFFFF; load = 1;
    tick_clk();
    check("hold_pattern", pattern_q, 16'h8001);
    for (int i = 0; i < 10; i++) begin
      tick_clk();
      if (step_tick) break;
    end
    check("swap_step", step, 4);
    check("swap_pattern", pattern_q, 16'hFFFF);

    // Pause with three cycles left in step 5, then resume.
    tempo_div = 28'd10;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_mode == MRun && m_step == 5 && m_rem == 3) found = 1;
      else tick_clk();
    end
    check("reach_step5", found, 1);
    pause = 1;
    tick_clk();
    check("paused_running", running, 0);
    repeat (20) tick_clk();
    check("paused_step", step, 5);
    start = 1;
    tick_clk();
    check("resume_no_tick", step_tick, 0);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      tick_clk();
      gap++;
      if (step_tick) break;
    end
    check("resume_gap", gap, 3);
    check("resume_step", step, 6);

    // Simultaneous control pulses.
    stop = 1;
    tick_clk();
    start = 1; stop = 1;
    tick_clk();
    check_zero("start_stop");
    start = 1;
    tick_clk();
    repeat (3) tick_clk();
    pause = 1; stop = 1;
    tick_clk();
    check_zero("pause_stop");

    // Gate length against an 8-cycle step with every step enabled.
    tempo_div = 28'd8;
    gl_tab = '{3, 0, 20};
`ifdef GATE_LEN_EN
    exp_tab = '{6, 0, 16};
`else
    exp_tab = '{16, 16, 16};
`endif
    for (int g = 0; g < 3; g++) begin
      stop = 1;
      tick_clk();
      gate_len = 28'(gl_tab[g]);
      start = 1;
      n_note = 0;
      for (int i = 0; i < 16; i++) begin
        tick_clk();
        n_note += int'(note_on);
      end
      check($sformatf("gate_%0d", gl_tab[g]), n_note, exp_tab[g]);
    end

    // Dividers below the minimum behave as 2.
    for (int d = 0; d < 2; d++) begin
      stop = 1;
      tick_clk();
      tempo_div = 28'(d);
      start = 1;
      n_tick = 0;
      for (int i = 0; i < 20; i++) begin
        tick_clk();
        n_tick += int'(step_tick);
      end
      check($sformatf("min_div_%0d", d), n_tick, 10);
    end

    // Random control traffic.
    tempo_div = 28'd3;
    for (int i = 0; i < 800; i++) begin
      start      = ($urandom_range(0, 9) == 0);
      stop       = ($urandom_range(0, 59) == 0);
      pause      = ($urandom_range(0, 29) == 0);
      load       = ($urandom_range(0, 7) == 0);
      pattern_in = 16'($urandom);
      if ($urandom_range(0, 49) == 0) tempo_div = 28'($urandom_range(0, 6));
      gate_len = 28'($urandom_range(0, 9));
      tick_clk();
    end

    // Asynchronous reset in the middle of a run.
    stop = 1;
    tick_clk();
    pattern_in = 16'hFFFF; load = 1; gate_len = 28'd100; tempo_div = 28'd5;
    tick_clk();
    start = 1;
    repeat (3) tick_clk();
    check("pre_reset_running", running, 1);
    #2 reset_n = 0;
    #1;
    check_zero("async_reset");
    check("async_reset_pattern", pattern_q, 0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1;
    tick_clk();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Run controller for the 16-step beat pattern datapath. It holds the step pattern, generates the tempo tick from the system clock, and advances the current step. It also gates the note-enable toward the tone player. It sits between the switch/key inputs and the note player, and replaces the free-running divider/counter/beat-select chain with a start/stop/pause state machine and double-buffered pattern loading.

## Interface
- STEPS, 16: pattern length; the step index is $clog2(STEPS) bits wide.
- DIV_W, 28: width of tempo_div, gate_len and the internal counters.
- clock  in  1  system clock (50 MHz on board).
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts from IDLE or resumes from PAUSE.
- stop  in  1  one-cycle pulse; returns to IDLE from any state.
- pause  in  1  one-cycle pulse; freezes playback while in RUN.
- load  in  1  one-cycle pulse; captures pattern_in.
- pattern_in  in  STEPS  new step pattern; bit i enables step i.
- tempo_div  in  DIV_W  clock cycles per step; values below 2 are treated as 2.
- gate_len  in  DIV_W  note-on length per step, in clock cycles.
- step  out  log2(STEPS)  current step index.
- step_tick  out  1  one-cycle pulse on the cycle a step begins.
- note_on  out  1  sound-enable to the note player.
- step_led  out  STEPS  one-hot of step while running/paused; zero in IDLE.
- pattern_q  out  STEPS  active pattern.
- running  out  1  high in RUN.

## Operation
- States: IDLE, RUN, PAUSE.
  - IDLE -> RUN on start: step=0, tempo counter loaded with tempo_div-1.
  - RUN -> PAUSE on pause.
  - PAUSE -> RUN on start.
  - Any state -> IDLE on stop.
- Priority: stop > pause > start. A start in RUN and a pause in PAUSE/IDLE are ignored.
- Tempo counter:
  - Counts down in RUN and holds in PAUSE.
  - At 0: step advances (STEPS-1 wraps to 0) and the counter reloads with the tempo_div-1 sampled on that cycle.
- Pattern load:
  - In IDLE or PAUSE, pattern_q <= pattern_in on the next edge.
  - In RUN, pattern_in goes to a shadow register and a pending flag is set. The shadow is copied to pattern_q on the same edge the step advances, so the new step already uses the new pattern.
  - Repeated loads before the boundary: the last one wins.
  - stop with a load pending: the pending pattern is applied on entry to IDLE.
- note_on = pattern_q[step] AND the gate is active AND state==RUN. note_on is 0 in PAUSE; the gate timer resumes where it stopped.
- Reset: state IDLE; step, step_tick, note_on, step_led, pattern_q, running, shadow, pending and counters all 0.

## Timing
- All outputs are registered.
- start sampled at edge N -> at N+1: running=1, step=0, step_tick=1, note_on=pattern_q[0] (gate permitting).
- In steady RUN, step_tick fires every max(tempo_div,2) cycles.
- stop at edge N -> at N+1: every output except pattern_q is 0.
- pause at edge N -> at N+1: running=0, note_on=0, step held. start at M -> the counter resumes at M+1 with its remaining count; no extra step_tick.
- A tempo_div change takes effect at the next reload, never mid-step.

## Configuration
- GATE_LEN_EN defined:
  - The gate opens at step_tick and stays active for min(gate_len, tempo_div) cycles.
  - gate_len=0 gives no notes.
  - gate_len >= tempo_div gives a full-step gate.
- Undefined:
  - The gate is active for the whole step.
  - The gate_len port remains but is ignored; no gate counter is synthesised.

## Structure
- Package beat_pkg holds:
  - the state enum (IDLE, RUN, PAUSE),
  - STEPS_DEFAULT=16,
  - MIN_DIV=2.
- One sub-module, tempo_tick: a down-counter with reload, hold, clear and terminal-count output. It is instantiated once for the step timer. Under GATE_LEN_EN it is instantiated again for the gate.

## Test plan
- Reset, then pattern_in=16'h8001, load, tempo_div=4, start -> step_tick at cycles 1, 5, 9…; note_on high only at steps 0 and 15; step wraps 15->0 after 64 cycles.
- Load 16'hFFFF while in RUN at step 3 mid-step -> pattern_q unchanged until the step-4 tick, then 16'hFFFF on that same edge.
- tempo_div=10, pause at step 5 with 3 cycles remaining, wait 20, start -> step 5 held for exactly 3 more RUN cycles; no extra tick.
- start and stop in the same cycle from IDLE -> stays IDLE, all outputs 0. pause and stop together in RUN -> IDLE.
- GATE_LEN_EN, tempo_div=8, pattern all ones:
  - gate_len=3 -> note_on high 3 of every 8 cycles.
  - gate_len=0 -> note_on never high.
  - gate_len=20 -> note_on continuously high.
- tempo_div=0 and then 1 -> step period of 2 cycles in both cases; reset_n asserted mid-RUN -> all outputs 0 immediately (asynchronously).
